// File: rtl/fpu_sgnj_pkg.sv
// Shared widths, variant encodings and the per-lane sign-injection function
// used by the FPU sign-injection responder.
package fpu_sgnj_pkg;

  localparam int XLEN          = 32;
  localparam int INST_FPU_BITS = 4;
  localparam int INST_FMT_BITS = 2;
  localparam int INST_FRM_BITS = 3;
  localparam int FP_FLAGS_BITS = 5;

  typedef enum logic [INST_FRM_BITS-1:0] {
    FRM_SGNJ  = 3'd0,
    FRM_SGNJN = 3'd1,
    FRM_SGNJX = 3'd2
  } frm_e;

  // Any variant outside SGNJ/SGNJN/SGNJX is a move: dataa is returned untouched.
  function automatic logic [XLEN-1:0] sgnj_lane(
    input logic [XLEN-1:0]          a,
    input logic [XLEN-1:0]          b,
    input logic [INST_FRM_BITS-1:0] frm,
    input logic                     is_double
  );
    logic [XLEN-1:0] res;
    logic            dbl;
    logic            sa;
    logic            sb;
    logic            sign;
    dbl = (XLEN == 64) && is_double;
    sa  = dbl ? a[XLEN-1] : a[31];
    sb  = dbl ? b[XLEN-1] : b[31];
    case (frm)
      FRM_SGNJ:  sign = sb;
      FRM_SGNJN: sign = ~sb;
      FRM_SGNJX: sign = sa ^ sb;
      default:   sign = sa;
    endcase
    res = a;
    if (dbl) begin
      res[XLEN-1] = sign;
    end else begin
      res[31] = sign;
      for (int i = 32; i < XLEN; i++) res[i] = 1'b1;
    end
    if (frm == FRM_SGNJ || frm == FRM_SGNJN || frm == FRM_SGNJX) return res;
    return a;
  endfunction

endpackage

// File: rtl/VX_fifo_queue.sv
// First-word fall-through FIFO: the head entry is read straight from the
// storage registers, so data_out is valid whenever empty is low.
module VX_fifo_queue #(
  parameter int DATAW = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             empty,
  output logic             full
);

  localparam int ADDRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW  = $clog2(DEPTH + 1);

  logic [DATAW-1:0] mem [DEPTH];
  logic [ADDRW-1:0] wr_ptr;
  logic [ADDRW-1:0] rd_ptr;
  logic [CNTW-1:0]  count;
  logic             do_pop;

  function automatic logic [ADDRW-1:0] next_ptr(input logic [ADDRW-1:0] p);
    return (p == ADDRW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop   = pop && !empty;
  assign empty    = (count == '0);
  assign full     = (count == CNTW'(DEPTH));
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      if (push && !do_pop)      count <= count + 1'b1;
      else if (!push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // Upstream credits make an overflowing push impossible.
  assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/fpu_sgnj_responder.sv
// FPU sign-injection responder: fixed-latency non-stalling pipeline feeding a
// credit-protected output FIFO, so no result is lost under response backpressure.
module fpu_sgnj_responder
  import fpu_sgnj_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter int TAG_WIDTH = 1,
  parameter int LATENCY   = 3,
  parameter int OUT_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               req_valid,
  input  logic [TAG_WIDTH-1:0]               req_tag,
  input  logic [INST_FPU_BITS-1:0]           req_op_type,
  input  logic [INST_FMT_BITS-1:0]           req_fmt,
  input  logic [INST_FRM_BITS-1:0]           req_frm,
  input  logic [NUM_LANES*XLEN-1:0]          req_dataa,
  input  logic [NUM_LANES*XLEN-1:0]          req_datab,
  input  logic [NUM_LANES*XLEN-1:0]          req_datac,
  output logic                               req_ready,
  output logic                               rsp_valid,
  output logic [TAG_WIDTH-1:0]               rsp_tag,
  output logic [NUM_LANES*XLEN-1:0]          rsp_result,
  output logic [NUM_LANES*FP_FLAGS_BITS-1:0] rsp_fflags,
  output logic                               rsp_has_fflags,
  input  logic                               rsp_ready
);

  localparam int LANES_W = NUM_LANES * XLEN;
  localparam int DATAW   = TAG_WIDTH + LANES_W;
  localparam int CNT_W   = $clog2(OUT_DEPTH + 1);

  logic               req_fire;
  logic               rsp_fire;
  logic [CNT_W-1:0]   pending;
  logic               fifo_empty;
  logic               fifo_full;
  logic [DATAW-1:0]   head;
  logic [LANES_W-1:0] result_p0;
  logic [LATENCY-1:0] vld_p;
  logic [DATAW-1:0]   data_p [LATENCY];
  logic               unused_inputs;

  assign unused_inputs = ^{req_op_type, req_fmt[INST_FMT_BITS-1:1], req_datac, fifo_full};

  // Ready depends only on the credit register, never on rsp_ready.
  assign req_ready = !reset && (pending != CNT_W'(OUT_DEPTH));
  assign req_fire  = req_valid && req_ready;
  assign rsp_valid = !fifo_empty;
  assign rsp_fire  = rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else if (req_fire && !rsp_fire) begin
      pending <= pending + 1'b1;
    end else if (!req_fire && rsp_fire) begin
      pending <= pending - 1'b1;
    end
  end

  always_comb begin
    result_p0 = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      result_p0[l*XLEN +: XLEN] = sgnj_lane(req_dataa[l*XLEN +: XLEN],
                                            req_datab[l*XLEN +: XLEN],
                                            req_frm, req_fmt[0]);
    end
  end

  // Stage 0 captures the fired request; each later stage shifts unconditionally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= req_fire;
      for (int s = 1; s < LATENCY; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  always_ff @(posedge clk) begin
    data_p[0] <= {req_tag, result_p0};
    for (int s = 1; s < LATENCY; s++) data_p[s] <= data_p[s-1];
  end

  // Last stage writes the output buffer.
  VX_fifo_queue #(
    .DATAW (DATAW),
    .DEPTH (OUT_DEPTH)
  ) out_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (vld_p[LATENCY-1]),
    .pop      (rsp_fire),
    .data_in  (data_p[LATENCY-1]),
    .data_out (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign rsp_tag        = head[DATAW-1 -: TAG_WIDTH];
  assign rsp_result     = head[LANES_W-1:0];
  assign rsp_fflags     = '0;
  assign rsp_has_fflags = 1'b0;

  assert property (@(posedge clk) disable iff (reset) pending <= CNT_W'(OUT_DEPTH));

endmodule

// File: tb/tb_fpu_sgnj_responder.sv
// Bench for fpu_sgnj_responder: vector table, backpressure, streaming,
// random traffic and mid-stream reset, all checked through a response scoreboard.
module tb_fpu_sgnj_responder;
  import fpu_sgnj_pkg::*;

  localparam int TAG_W     = 8;
  localparam int LATENCY   = 3;
  localparam int OUT_DEPTH = 5;
  localparam int NV        = 8;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     req_valid;
  logic [TAG_W-1:0]         req_tag;
  logic [INST_FPU_BITS-1:0] req_op_type;
  logic [INST_FMT_BITS-1:0] req_fmt;
  logic [INST_FRM_BITS-1:0] req_frm;
  logic [XLEN-1:0]          req_dataa;
  logic [XLEN-1:0]          req_datab;
  logic [XLEN-1:0]          req_datac;
  logic                     req_ready;
  logic                     rsp_valid;
  logic [TAG_W-1:0]         rsp_tag;
  logic [XLEN-1:0]          rsp_result;
  logic [FP_FLAGS_BITS-1:0] rsp_fflags;
  logic                     rsp_has_fflags;
  logic                     rsp_ready;

  fpu_sgnj_responder #(
    .NUM_LANES (1),
    .TAG_WIDTH (TAG_W),
    .LATENCY   (LATENCY),
    .OUT_DEPTH (OUT_DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_tag        (req_tag),
    .req_op_type    (req_op_type),
    .req_fmt        (req_fmt),
    .req_frm        (req_frm),
    .req_dataa      (req_dataa),
    .req_datab      (req_datab),
    .req_datac      (req_datac),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_tag        (rsp_tag),
    .rsp_result     (rsp_result),
    .rsp_fflags     (rsp_fflags),
    .rsp_has_fflags (rsp_has_fflags),
    .rsp_ready      (rsp_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
  } exp_t;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [2:0]       frm;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [31:0]      exp;
  } vec_t;

  exp_t        sb [$];
  exp_t        mon_e;
  vec_t        vec [NV];
  int          checks = 0;
  int          errors = 0;
  int          fire_cnt = 0;
  int          rsp_cnt = 0;
  int          model_pending = 0;
  int          max_pending = 0;
  int          n;
  int          base;
  int          rbase;
  logic        got;
  logic        have;
  logic        stale;
  logic [TAG_W-1:0] held_tag;
  logic [31:0] held_res;

  function automatic logic [31:0] model_sgnj(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] frm);
    case (frm)
      3'd0:    return {b[31], a[30:0]};
      3'd1:    return {~b[31], a[30:0]};
      3'd2:    return {a[31] ^ b[31], a[30:0]};
      default: return a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (model_pending != 0 && k < 80) begin
      @(negedge clk);
      k++;
    end
    chk(name, model_pending, 0);
  endtask

  // Monitor: credit model, request capture and response scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      chk("req_ready_model", req_ready, (model_pending != OUT_DEPTH));
      if (req_valid && req_ready) begin
        sb.push_back({req_tag, model_sgnj(req_dataa, req_datab, req_frm)});
        fire_cnt++;
        model_pending++;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        model_pending--;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got tag 0x%0h, expected no response", rsp_tag);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_tag", rsp_tag, mon_e.tag);
          chk("sb_result", rsp_result, mon_e.res);
          chk("sb_fflags", {rsp_has_fflags, rsp_fflags}, 0);
        end
      end
      if (model_pending > max_pending) max_pending = model_pending;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{8'd5,  3'd0, 32'h3F800000, 32'hC0000000, 32'hBF800000};
    vec[1] = '{8'd6,  3'd1, 32'hBF800000, 32'hBF800000, 32'h3F800000};
    vec[2] = '{8'd7,  3'd2, 32'hBF800000, 32'hC0000000, 32'h3F800000};
    vec[3] = '{8'd8,  3'd7, 32'h12345678, 32'hFFFFFFFF, 32'h12345678};
    vec[4] = '{8'd9,  3'd3, 32'h80000001, 32'h00000000, 32'h80000001};
    vec[5] = '{8'd10, 3'd0, 32'hBF800000, 32'h00000000, 32'h3F800000};
    vec[6] = '{8'd11, 3'd1, 32'h7FC00000, 32'h00000000, 32'hFFC00000};
    vec[7] = '{8'd12, 3'd2, 32'h80000000, 32'h80000000, 32'h00000000};

    reset = 1'b1;
    req_valid = 1'b0;
    req_tag = '0;
    req_op_type = '0;
    req_fmt = '0;
    req_frm = '0;
    req_dataa = '0;
    req_datab = '0;
    req_datac = '0;
    rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_req_ready", req_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1);

    // Vector table: one request at a time, latency and result checked directly.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_tag   = vec[i].tag;
      req_frm   = vec[i].frm;
      req_dataa = vec[i].a;
      req_datab = vec[i].b;
      req_datac = $urandom;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      got = 1'b0;
      while (!got && n < 20) begin
        @(negedge clk);
        n++;
        if (rsp_valid) got = 1'b1;
      end
      chk("vec_latency", n, LATENCY + 1);
      chk("vec_result", rsp_result, vec[i].exp);
      chk("vec_tag", rsp_tag, vec[i].tag);
      chk("vec_fflags", rsp_fflags, 0);
    end
    drain("vec_drain");

    // Backpressure: only OUT_DEPTH requests may be accepted.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    base = fire_cnt;
    have = 1'b0;
    for (int i = 0; i < 12; i++) begin
      req_valid = 1'b1;
      req_tag   = 8'h40 + 8'(i);
      req_frm   = 3'($urandom_range(0, 7));
      req_dataa = $urandom;
      req_datab = $urandom;
      @(negedge clk);
      if (rsp_valid) begin
        if (!have) begin
          held_tag = rsp_tag;
          held_res = rsp_result;
          have = 1'b1;
        end else begin
          chk("hold_tag", rsp_tag, held_tag);
          chk("hold_result", rsp_result, held_res);
        end
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("bp_fires", fire_cnt - base, OUT_DEPTH);
    @(negedge clk);
    chk("bp_ready_low", req_ready, 0);
    rbase = rsp_cnt;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("full_ready_same_cycle", req_ready, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("full_ready_next_cycle", req_ready, 1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain("bp_drain");
    chk("bp_rsps", rsp_cnt - rbase, OUT_DEPTH);

    // Streaming: 100 back-to-back requests with the consumer always ready.
    @(posedge clk); #1;
    base = fire_cnt;
    rbase = rsp_cnt;
    for (int i = 0; i < 100; i++) begin
      req_valid = 1'b1;
      req_tag   = 8'(i);
      req_frm   = 3'($urandom_range(0, 7));
      req_dataa = $urandom;
      req_datab = $urandom;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("stream_fires", fire_cnt - base, 100);
    drain("stream_drain");
    chk("stream_rsps", rsp_cnt - rbase, 100);

    // Random traffic with a toggling consumer.
    base = fire_cnt;
    rbase = rsp_cnt;
    max_pending = 0;
    for (int i = 0; i < 400; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      rsp_ready = 1'($urandom_range(0, 1));
      req_tag   = 8'($urandom);
      req_frm   = 3'($urandom_range(0, 7));
      req_dataa = $urandom;
      req_datab = $urandom;
      req_datac = $urandom;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain("rand_drain");
    chk("rand_rsps_match_fires", rsp_cnt - rbase, fire_cnt - base);
    chk("rand_max_pending", (max_pending <= OUT_DEPTH), 1);

    // Reset with one response buffered and three requests in the pipeline.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_tag   = 8'hA0 + 8'(i);
      req_dataa = $urandom;
      req_datab = $urandom;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("pre_reset_rsp_valid", rsp_valid, 1);
    reset = 1'b1;
    sb.delete();
    model_pending = 0;
    #1;
    chk("reset_mid_rsp_valid", rsp_valid, 0);
    chk("reset_mid_req_ready", req_ready, 0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", req_ready, 1);
    stale = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) stale = 1'b1;
    end
    chk("post_reset_no_stale", stale, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_sgnj_responder.md
# fpu_sgnj_responder

Responder end of the FPU request/response protocol: a sign-injection execution unit that sits on one `req_out`/`rsp_out` port pair of the FPU arbiter. It accepts tagged FPU requests, computes FSGNJ/FSGNJN/FSGNJX (or a move) per lane through a fixed-latency, non-stallable pipeline, and returns the result with the unmodified tag. A credit counter plus an output FIFO guarantee that no result is ever dropped under response backpressure.

## Interface
- NUM_LANES, 1, lanes per request
- TAG_WIDTH, 1, opaque tag width; this width includes the arbiter's inserted select bits
- LATENCY, 3, pipeline stages from request fire to FIFO write; ≥1
- OUT_DEPTH, 4, output FIFO entries and total credit limit; ≥2; full throughput needs ≥ LATENCY+1

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request valid
- req_tag  in  TAG_WIDTH  request tag
- req_op_type  in  `INST_FPU_BITS  opcode; ignored
- req_fmt  in  `INST_FMT_BITS  format; bit0=1 selects double (legal only when `XLEN==64)
- req_frm  in  `INST_FRM_BITS  variant: 0 SGNJ, 1 SGNJN, 2 SGNJX, other values move dataa unchanged
- req_dataa / req_datab / req_datac  in  NUM_LANES×`XLEN each  operands; datac ignored
- req_ready  out  1  request accepted when high with req_valid
- rsp_valid  out  1  response valid
- rsp_tag  out  TAG_WIDTH  echoed tag
- rsp_result  out  NUM_LANES×`XLEN  results
- rsp_fflags  out  NUM_LANES×`FP_FLAGS_BITS  always 0
- rsp_has_fflags  out  1  always 0
- rsp_ready  in  1  consumer ready

## Operation
- Request fire = req_valid & req_ready. Response fire = rsp_valid & rsp_ready.
- Result per lane uses sign bit position S = 63 for double, 31 for single:
  - SGNJ: sign = b[S]
  - SGNJN: sign = ~b[S]
  - SGNJX: sign = a[S]^b[S]
  - magnitude bits are a[S-1:0].
  - Single with `XLEN==64: result[63:32] = all ones (NaN-boxing).
- Pipeline: LATENCY register stages. Each stage holds valid, tag, and result. The stages never stall. Stage-LATENCY valid writes the FIFO.
- Credit counter `pending`, 0..OUT_DEPTH: +1 on request fire, −1 on response fire; both in the same cycle leaves it unchanged.
- req_ready = (pending != OUT_DEPTH). It is a function of registers only; there is no combinational path from rsp_ready.
- FIFO: OUT_DEPTH entries, first-word fall-through from registered head. rsp_valid = FIFO not empty. Overflow is impossible by construction; an assertion checks push & full never occurs.
- Responses return in request order.

## Timing
- Reset values: all pipe valids 0, FIFO empty, pending 0, rsp_valid 0, req_ready 0 while reset is asserted and 1 from the first cycle after release. In-flight work is discarded on reset.
- Latency: a request fired at edge t is visible on rsp_valid in the cycle after edge t+LATENCY when the FIFO was empty.
- Throughput: 1 request per cycle while rsp_ready stays high and OUT_DEPTH ≥ LATENCY+1.
- Full condition: pending==OUT_DEPTH drops req_ready. A response fire in that cycle raises req_ready in the next cycle, not the same cycle.
- Data held stable: rsp_tag and rsp_result stay stable while rsp_valid & !rsp_ready.
- FIFO boundaries: a FIFO push into an empty FIFO combined with a simultaneous pop is not possible, because the FIFO was empty. A push and a pop in the same cycle while the FIFO is non-empty keep the count.
- Pointers wrap modulo OUT_DEPTH.

## Structure
- Shared package `fpu_sgnj_pkg`:
  - FRM constants FRM_SGNJ=0, FRM_SGNJN=1, FRM_SGNJX=2
  - per-lane result computation function
- Sub-module: reuse `VX_fifo_queue` (DATAW = TAG_WIDTH + NUM_LANES×`XLEN, DEPTH = OUT_DEPTH) for the output buffer.
- Credit counter and pipeline stay in the top module.

## Test plan
- SGNJ single, a=0x3F800000, b=0xC0000000, rsp_ready=1, tag=5 -> after LATENCY+1 cycles rsp_result=0xBF800000, rsp_tag=5, rsp_fflags=0.
- SGNJN a=0xBF800000, b=0xBF800000 -> 0x3F800000. SGNJX a=0xBF800000, b=0xC0000000 -> 0x3F800000. frm=7 -> dataa unchanged.
- Backpressure: rsp_ready=0, continuous valid requests -> exactly OUT_DEPTH fires, then req_ready=0. Raise rsp_ready -> all OUT_DEPTH responses return in tag order, with no loss.
- Streaming: LATENCY=3, OUT_DEPTH=4, 100 back-to-back requests, rsp_ready=1 -> 100 fires in 100 cycles and responses in order.
- Random rsp_ready toggling (50%), random requests -> scoreboard match, pending never exceeds OUT_DEPTH, no FIFO overflow assertion.
- Reset asserted mid-stream with 3 requests in flight -> rsp_valid=0 immediately, no stale response after release, req_ready=1 on the first post-reset cycle.
